// File: rtl/display_ctrl.sv
// display_ctrl
// Sequential binary-to-BCD converter feeding s7_display.i_bcd_data.
// A value is accepted over a valid/ready handshake and converted with an
// iterative shift-add-3 (double-dabble) datapath, one input bit per clock.
// Values above MAX_VAL saturate every digit to 9 and raise o_overflow.
//
// Ports:
//   i_clk       - clock, rising edge
//   i_rst       - asynchronous active-low reset
//   i_valid     - i_bin holds a value to convert
//   i_bin       - unsigned binary input, BIN_WIDTH bits
//   o_ready     - controller idle and able to accept (decoded from state)
//   o_bcd_data  - registered BCD digits, digit k at [4k+3:4k], digit 0 LSD
//   o_bcd_valid - one-cycle pulse when o_bcd_data is updated
//   o_overflow  - registered, set when the last accepted value exceeded MAX_VAL
module display_ctrl #(
  parameter int DISPLAYS_NUM = 4,
  parameter int BIN_WIDTH    = 14
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [BIN_WIDTH-1:0]      i_bin,
  output logic                      o_ready,
  output logic [DISPLAYS_NUM*4-1:0] o_bcd_data,
  output logic                      o_bcd_valid,
  output logic                      o_overflow
);

  localparam int BCD_W = DISPLAYS_NUM * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // 10**n evaluated at 64 bits so MAX_VAL and the compare never truncate.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DISPLAYS_NUM) - 64'd1;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int k = 0; k < DISPLAYS_NUM; k++) begin
      if (d[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = d[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = d[4*k +: 4];
      end
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                   state_r, state_nx_s;
  logic [BIN_WIDTH-1:0]     bin_r, bin_nx_s;
  logic [BCD_W-1:0]         bcd_r, bcd_nx_s, bcd_adj_s;
  logic [CNT_W-1:0]         cnt_r, cnt_nx_s;
  logic                     ovf_r, ovf_nx_s;
  logic [BCD_W-1:0]         data_r, data_nx_s;
  logic                     bcd_valid_r, bcd_valid_nx_s;
  logic                     overflow_r, overflow_nx_s;
  logic [BCD_W+BIN_WIDTH-1:0] shift_s;

  // Next-state and datapath update logic.
  always_comb begin
    state_nx_s     = state_r;
    bin_nx_s       = bin_r;
    bcd_nx_s       = bcd_r;
    cnt_nx_s       = cnt_r;
    ovf_nx_s       = ovf_r;
    data_nx_s      = data_r;
    bcd_valid_nx_s = 1'b0;
    overflow_nx_s  = overflow_r;
    bcd_adj_s      = bcd_adjust(bcd_r);
    // MSB of bin_r moves into the LSB of digit 0.
    shift_s        = {bcd_adj_s, bin_r} << 1'b1;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          bin_nx_s   = i_bin;
          bcd_nx_s   = {BCD_W{1'b0}};
          cnt_nx_s   = CNT_W'(BIN_WIDTH);
          ovf_nx_s   = (64'(i_bin) > MAX_VAL);
          state_nx_s = SHIFT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT: begin
        bcd_nx_s = shift_s[BCD_W+BIN_WIDTH-1 -: BCD_W];
        bin_nx_s = shift_s[BIN_WIDTH-1:0];
        cnt_nx_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        // Conversion always runs to completion so latency is fixed; an
        // overflowing result is simply replaced by all-nines.
        if (ovf_r) begin
          data_nx_s     = {DISPLAYS_NUM{4'h9}};
          overflow_nx_s = 1'b1;
        end else begin
          data_nx_s     = bcd_r;
          overflow_nx_s = 1'b0;
        end
        bcd_valid_nx_s = 1'b1;
        state_nx_s     = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bin_r       <= {BIN_WIDTH{1'b0}};
      bcd_r       <= {BCD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      data_r      <= {BCD_W{1'b0}};
      bcd_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      bin_r       <= bin_nx_s;
      bcd_r       <= bcd_nx_s;
      cnt_r       <= cnt_nx_s;
      ovf_r       <= ovf_nx_s;
      data_r      <= data_nx_s;
      bcd_valid_r <= bcd_valid_nx_s;
      overflow_r  <= overflow_nx_s;
    end
  end

  assign o_ready     = (state_r == IDLE);
  assign o_bcd_data  = data_r;
  assign o_bcd_valid = bcd_valid_r;
  assign o_overflow  = overflow_r;

endmodule

// File: tb/tb_display_ctrl.sv
// Directed testbench for display_ctrl: default 4-digit/14-bit instance (a_*)
// and a 2-digit/7-bit instance (b_*) sharing clock and reset.
module tb_display_ctrl;

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready, a_bv, a_ovf;
  logic [13:0] a_bin;
  logic [15:0] a_data;
  logic        b_valid, b_ready, b_bv, b_ovf;
  logic [6:0]  b_bin;
  logic [7:0]  b_data;

  int checks   = 0;
  int failures = 0;

  display_ctrl #(.DISPLAYS_NUM(4), .BIN_WIDTH(14)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_bin(a_bin),
    .o_ready(a_ready), .o_bcd_data(a_data), .o_bcd_valid(a_bv), .o_overflow(a_ovf)
  );

  display_ctrl #(.DISPLAYS_NUM(2), .BIN_WIDTH(7)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_bin(b_bin),
    .o_ready(b_ready), .o_bcd_data(b_data), .o_bcd_valid(b_bv), .o_overflow(b_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a value to instance A (called at a negedge).
  task automatic start_a(input string tag, input logic [13:0] v);
    check({tag, "_rdy_pre"}, 32'(a_ready), 32'd1);
    a_valid = 1'b1;
    a_bin   = v;
  endtask

  // Follow an A conversion to its o_bcd_valid cycle; returns at that negedge.
  task automatic wait_a(input string tag, input logic [15:0] exp_d, input logic exp_o,
                        input logic hold, input logic [13:0] next_v);
    int low;
    int changes;
    logic got;
    logic [15:0] prev;
    low = 0; changes = 0; got = 1'b0; prev = a_data;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (hold) a_bin = next_v;
        else a_valid = 1'b0;
      end
      if (a_bv) got = 1'b1;
      else begin
        if (!a_ready) low++;
        if (a_data !== prev) changes++;
      end
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_data"}, 32'(a_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(a_ovf), 32'(exp_o));
    check({tag, "_rdy"}, 32'(a_ready), 32'd1);
    check({tag, "_lat"}, 32'(low), 32'd15);
    check({tag, "_hold"}, 32'(changes), 32'd0);
  endtask

  task automatic conv_b(input string tag, input logic [6:0] v, input logic [7:0] exp_d,
                        input logic exp_o);
    int low;
    logic got;
    check({tag, "_rdy_pre"}, 32'(b_ready), 32'd1);
    b_valid = 1'b1;
    b_bin   = v;
    low = 0; got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (i == 0) b_valid = 1'b0;
      if (b_bv) got = 1'b1;
      else if (!b_ready) low++;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    check({tag, "_data"}, 32'(b_data), 32'(exp_d));
    check({tag, "_ovf"}, 32'(b_ovf), 32'(exp_o));
    check({tag, "_lat"}, 32'(low), 32'd8);
  endtask

  initial begin
    int pulses;
    rst = 1'b0;
    a_valid = 1'b0; a_bin = 14'd0;
    b_valid = 1'b0; b_bin = 7'd0;
    repeat (2) @(negedge clk);
    check("rst_a_rdy", 32'(a_ready), 32'd1);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_a_bv", 32'(a_bv), 32'd0);
    check("rst_a_ovf", 32'(a_ovf), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic conversion and single-cycle pulse.
    start_a("basic", 14'd1234);
    wait_a("basic", 16'h1234, 1'b0, 1'b0, 14'd0);
    @(negedge clk);
    check("basic_pulse_end", 32'(a_bv), 32'd0);
    check("basic_data_held", 32'(a_data), 32'h1234);

    // Range limits and overflow.
    start_a("zero", 14'd0);
    wait_a("zero", 16'h0000, 1'b0, 1'b0, 14'd0);
    @(negedge clk);
    start_a("max", 14'd9999);
    wait_a("max", 16'h9999, 1'b0, 1'b0, 14'd0);
    @(negedge clk);
    start_a("ovf", 14'd10000);
    wait_a("ovf", 16'h9999, 1'b1, 1'b0, 14'd0);
    @(negedge clk);
    start_a("after_ovf", 14'd42);
    wait_a("after_ovf", 16'h0042, 1'b0, 1'b0, 14'd0);

    // Busy: 5678 held on the input during the 1234 conversion, accepted
    // back-to-back in the o_bcd_valid cycle.
    @(negedge clk);
    start_a("busy1", 14'd1234);
    wait_a("busy1", 16'h1234, 1'b0, 1'b1, 14'd5678);
    wait_a("busy2", 16'h5678, 1'b0, 1'b0, 14'd0);

    // Reset in the middle of a 4321 conversion.
    @(negedge clk);
    start_a("mid", 14'd4321);
    repeat (7) @(negedge clk);
    check("mid_busy", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("mid_rst_rdy", 32'(a_ready), 32'd1);
    check("mid_rst_data", 32'(a_data), 32'd0);
    check("mid_rst_bv", 32'(a_bv), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (a_bv) pulses++;
    end
    check("mid_no_pulse", 32'(pulses), 32'd0);
    start_a("post_rst", 14'd7);
    wait_a("post_rst", 16'h0007, 1'b0, 1'b0, 14'd0);

    // Two-digit, 7-bit instance.
    @(negedge clk);
    conv_b("b99", 7'd99, 8'h99, 1'b0);
    @(negedge clk);
    conv_b("b100", 7'd100, 8'h99, 1'b1);
    @(negedge clk);
    conv_b("b57", 7'd57, 8'h57, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
